// File: rtl/core_pkg.sv
// Shared constants for the MIPS core pipeline: bundle widths, control bit
// positions and the hard-wired zero register number.
package core_pkg;

   localparam int CTRL_W  = 6;
   localparam int ALUOP_W = 4;

   // Control bundle layout {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
   localparam int CTRL_REG_WRITE  = 5;
   localparam int CTRL_MEM_READ   = 4;
   localparam int CTRL_MEM_WRITE  = 3;
   localparam int CTRL_MEM_TO_REG = 2;
   localparam int CTRL_ALU_SRC    = 1;
   localparam int CTRL_REG_DST    = 0;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_bypass_sel.sv
// Operand select between a register value and the WB write data.
// The WB value wins only when WB really writes the same, non-zero register;
// register $0 always keeps the supplied value.
module wb_bypass_sel
   import core_pkg::*;
(
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_rd_data,
   input  logic        i_wb_reg_write,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_operand
);

   logic w_hit;

   assign w_hit     = i_wb_reg_write && (i_wb_addr != REG_ZERO) && (i_wb_addr == i_rd_addr);
   assign o_operand = w_hit ? i_wb_data : i_rd_data;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register. Captures decoded ID state for EXE with
// flush > stall > load priority. Operands pass through a WB bypass on load,
// and a held (stalled) valid instruction has its operands refreshed from WB so
// a write that lands during the stall is not lost once forwarding moves on.
module id_exe_reg #(
   parameter int CTRL_W  = core_pkg::CTRL_W,
   parameter int ALUOP_W = core_pkg::ALUOP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [31:0]        id_pc,
   input  logic [31:0]        id_rs_data,
   input  logic [31:0]        id_rt_data,
   input  logic [4:0]         id_rs_addr,
   input  logic [4:0]         id_rt_addr,
   input  logic [4:0]         id_rd_addr,
   input  logic [31:0]        id_imm,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic [CTRL_W-1:0]  id_ctrl,
   input  logic               wb_reg_write,
   input  logic [4:0]         wb_addr,
   input  logic [31:0]        wb_data,
   output logic               ex_valid,
   output logic [31:0]        ex_pc,
   output logic [31:0]        ex_rs_data,
   output logic [31:0]        ex_rt_data,
   output logic [4:0]         ex_rs_addr,
   output logic [4:0]         ex_rt_addr,
   output logic [4:0]         ex_dest_addr,
   output logic [31:0]        ex_imm,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [CTRL_W-1:0]  ex_ctrl
);

   logic               r_valid;
   logic [31:0]        r_pc;
   logic [31:0]        r_rs_data;
   logic [31:0]        r_rt_data;
   logic [4:0]         r_rs_addr;
   logic [4:0]         r_rt_addr;
   logic [4:0]         r_dest_addr;
   logic [31:0]        r_imm;
   logic [ALUOP_W-1:0] r_alu_op;
   logic [CTRL_W-1:0]  r_ctrl;

   logic [31:0] w_load_rs;
   logic [31:0] w_load_rt;
   logic [31:0] w_hold_rs;
   logic [31:0] w_hold_rt;
   logic        w_hold_wb_we;
   logic [4:0]  w_load_dest;

   // Refresh applies only to a real instruction sitting in EX.
   assign w_hold_wb_we = wb_reg_write & r_valid;

   // Destination is rd or rt for writing instructions, $0 otherwise.
   assign w_load_dest = id_ctrl[core_pkg::CTRL_REG_WRITE]
                      ? (id_ctrl[core_pkg::CTRL_REG_DST] ? id_rd_addr : id_rt_addr)
                      : core_pkg::REG_ZERO;

   wb_bypass_sel u_load_rs (
      .i_rd_addr      (id_rs_addr),
      .i_rd_data      (id_rs_data),
      .i_wb_reg_write (wb_reg_write),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_data),
      .o_operand      (w_load_rs)
   );

   wb_bypass_sel u_load_rt (
      .i_rd_addr      (id_rt_addr),
      .i_rd_data      (id_rt_data),
      .i_wb_reg_write (wb_reg_write),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_data),
      .o_operand      (w_load_rt)
   );

   wb_bypass_sel u_hold_rs (
      .i_rd_addr      (r_rs_addr),
      .i_rd_data      (r_rs_data),
      .i_wb_reg_write (w_hold_wb_we),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_data),
      .o_operand      (w_hold_rs)
   );

   wb_bypass_sel u_hold_rt (
      .i_rd_addr      (r_rt_addr),
      .i_rd_data      (r_rt_data),
      .i_wb_reg_write (w_hold_wb_we),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_data),
      .o_operand      (w_hold_rt)
   );

   // Pipeline register update: flush bubbles, stall holds (with WB refresh), else load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_rs_addr   <= '0;
         r_rt_addr   <= '0;
         r_dest_addr <= '0;
         r_imm       <= '0;
         r_alu_op    <= '0;
         r_ctrl      <= '0;
      end else if (flush || (!stall && !id_valid)) begin
         // Bubble: only the fields that can cause side effects are cleared.
         r_valid     <= 1'b0;
         r_ctrl      <= '0;
         r_alu_op    <= '0;
         r_dest_addr <= '0;
      end else if (stall) begin
         r_rs_data   <= w_hold_rs;
         r_rt_data   <= w_hold_rt;
      end else begin
         r_valid     <= 1'b1;
         r_pc        <= id_pc;
         r_rs_data   <= w_load_rs;
         r_rt_data   <= w_load_rt;
         r_rs_addr   <= id_rs_addr;
         r_rt_addr   <= id_rt_addr;
         r_dest_addr <= w_load_dest;
         r_imm       <= id_imm;
         r_alu_op    <= id_alu_op;
         r_ctrl      <= id_ctrl;
      end
   end

   assign ex_valid     = r_valid;
   assign ex_pc        = r_pc;
   assign ex_rs_data   = r_rs_data;
   assign ex_rt_data   = r_rt_data;
   assign ex_rs_addr   = r_rs_addr;
   assign ex_rt_addr   = r_rt_addr;
   assign ex_dest_addr = r_dest_addr;
   assign ex_imm       = r_imm;
   assign ex_alu_op    = r_alu_op;
   assign ex_ctrl      = r_ctrl;

endmodule
